// File: rtl/alu_stage.sv
// alu_stage: registered execute stage with a valid/ready handshake and flagged result.
// Define ALU_MUL_EN to build the iterative shift-add multiplier for op 111.
module alu_stage #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             carry,
    output logic             zero,
    output logic             busy
);
    localparam int SH = $clog2(WIDTH);
    localparam int CW = SH + 1;

    typedef enum logic [1:0] {IDLE = 2'd0, EXEC = 2'd1, HOLD = 2'd2} state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             carry_q, carry_d;
    logic             accept, is_mul;
    logic [WIDTH-1:0] alu_res;
    logic             alu_carry;

`ifdef ALU_MUL_EN
    logic [2*WIDTH-1:0] acc_q, acc_d, acc_step;
    logic [WIDTH-1:0]   mcand_q, mcand_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [WIDTH:0]     acc_sum;

    assign is_mul = (op == 3'b111);
    // High half accumulates partial products; low half holds the unconsumed multiplier bits.
    assign acc_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, mcand_q} : '0);
    assign acc_step = {acc_sum, acc_q[WIDTH-1:1]};
`else
    assign is_mul = 1'b0;
`endif

    assign accept = in_valid && in_ready;

    always_comb begin
        alu_res   = '0;
        alu_carry = 1'b0;
        case (op)
            3'b000:  {alu_carry, alu_res} = {1'b0, a} + {1'b0, b};
            3'b001:  {alu_carry, alu_res} = {1'b0, a} - {1'b0, b};
            3'b010:  alu_res = a & b;
            3'b011:  alu_res = a | b;
            3'b100:  alu_res = a ^ b;
            3'b101:  alu_res = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
            3'b110:  alu_res = a << b[SH-1:0];
            default: alu_res = '0;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            result_q <= '0;
            carry_q  <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples pre-edge values.
            state_q  <= state_d;
            result_q <= result_d;
            carry_q  <= carry_d;
        end
    end

`ifdef ALU_MUL_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            // NOTE: the accumulator and counter are cleared so an aborted multiply leaves no residue.
            acc_q   <= '0;
            mcand_q <= '0;
            cnt_q   <= '0;
        end else begin
            acc_q   <= acc_d;
            mcand_q <= mcand_d;
            cnt_q   <= cnt_d;
        end
    end
`endif

    always_comb begin
        // NOTE: every register defaults to its current value so no branch infers a latch.
        state_d  = state_q;
        result_d = result_q;
        carry_d  = carry_q;
`ifdef ALU_MUL_EN
        acc_d    = acc_q;
        mcand_d  = mcand_q;
        cnt_d    = cnt_q;
`endif
        case (state_q)
            IDLE, HOLD: begin
                if (accept) begin
                    if (is_mul) begin
`ifdef ALU_MUL_EN
                        acc_d   = {{WIDTH{1'b0}}, b};
                        mcand_d = a;
                        cnt_d   = CW'(WIDTH);
                        state_d = EXEC;
`endif
                    end else begin
                        result_d = alu_res;
                        carry_d  = alu_carry;
                        state_d  = HOLD;
                    end
                end else if (state_q == HOLD && out_ready) begin
                    state_d = IDLE;
                end
            end
            EXEC: begin
`ifdef ALU_MUL_EN
                acc_d = acc_step;
                cnt_d = cnt_q - CW'(1);
                if (cnt_q == CW'(1)) begin
                    result_d = acc_step[WIDTH-1:0];
                    carry_d  = |acc_step[2*WIDTH-1:WIDTH];
                    state_d  = HOLD;
                end
`else
                state_d = IDLE;
`endif
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        in_ready  = (state_q == IDLE) || (state_q == HOLD && out_ready);
        out_valid = (state_q == HOLD);
`ifdef ALU_MUL_EN
        busy      = (state_q == EXEC);
`else
        busy      = 1'b0;
`endif
        result    = result_q;
        carry     = carry_q;
        zero      = out_valid && (result_q == '0);
    end

endmodule

// File: tb/tb_alu_stage.sv
// Testbench for alu_stage: directed vectors plus an arithmetic reference model
// checked against the DUT output on every cycle out_valid is high.
module tb_alu_stage;
    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid, in_ready, out_valid, out_ready;
    logic [2:0]   op;
    logic [W-1:0] a, b, result;
    logic         carry, zero, busy;

    int n_vec = 0;
    int n_bad = 0;

    typedef struct {
        logic [W-1:0] r;
        logic         c;
        logic         z;
    } exp_t;

    exp_t exp_q[$];

    alu_stage #(.WIDTH(W)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .op(op), .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready),
        .result(result), .carry(carry), .zero(zero), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic exp_t model(input logic [2:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
        longint ux, uy, s, full, sx, sy;
        exp_t   e;
        ux   = longint'(x);
        uy   = longint'(y);
        full = longint'(1) << W;
        sx   = (ux >= full / 2) ? ux - full : ux;
        sy   = (uy >= full / 2) ? uy - full : uy;
        s    = 0;
        e.c  = 1'b0;
        case (o)
            3'd0: begin s = ux + uy; e.c = (s >= full); end
            3'd1: begin s = ux - uy + full; e.c = (ux < uy); end
            3'd2: s = ux & uy;
            3'd3: s = ux | uy;
            3'd4: s = ux ^ uy;
            3'd5: s = (sx < sy) ? 1 : 0;
            3'd6: s = ux << (uy % W);
            default: begin
`ifdef ALU_MUL_EN
                s = ux * uy; e.c = (s >= full);
`else
                s = 0;
`endif
            end
        endcase
        e.r = s[W-1:0];
        e.z = (e.r == '0);
        return e;
    endfunction

    // Compare process: front of queue is the transaction currently presented.
    always @(negedge clk) begin
        if (!rst) begin
            if (out_valid) begin
                if (exp_q.size() == 0) begin
                    n_vec++;
                    n_bad++;
                    $display("FAIL unexpected_out_valid: got 1 expected 0 at %0t", $time);
                end else begin
                    check("model_result", result, exp_q[0].r);
                    check("model_carry", carry, exp_q[0].c);
                    check("model_zero", zero, exp_q[0].z);
                    check("model_busy_in_hold", busy, 0);
                    if (out_ready) void'(exp_q.pop_front());
                end
            end
            if (in_valid && in_ready) exp_q.push_back(model(op, a, b));
        end
    end

    task automatic run_op(input logic [2:0] o, input logic [W-1:0] x, input logic [W-1:0] y,
                          output int lat, output int bcnt);
        int guard;
        in_valid = 1'b1; op = o; a = x; b = y;
        guard = 0;
        @(negedge clk);
        while (!in_ready && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        if (!in_ready) check("accept_timeout", 0, 1);
        @(posedge clk);
        #1;
        in_valid = 1'b0; op = 3'(($urandom)); a = W'($urandom); b = W'($urandom);
        lat  = 1;
        bcnt = 0;
        @(negedge clk);
        while (!out_valid && lat < 40) begin
            bcnt += int'(busy);
            lat++;
            @(negedge clk);
        end
        if (!out_valid) check("result_timeout", 0, 1);
    endtask

    task automatic drain();
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic [2:0]   o;
        logic [W-1:0] x, y, r;
        logic         c;
    } vec_t;

    initial begin
        int   lat, bcnt;
        vec_t vecs[8];
        vec_t tp[6];

        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; op = '0; a = '0; b = '0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_out_valid", out_valid, 0);
        check("rst_result", result, 0);
        check("rst_carry", carry, 0);
        check("rst_zero", zero, 0);
        check("rst_busy", busy, 0);
        check("rst_in_ready", in_ready, 1);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // op, a, b, result, carry
        vecs[0] = '{3'd0, 8'd200, 8'd100, 8'd44,  1'b1};
        vecs[1] = '{3'd1, 8'd5,   8'd7,   8'd254, 1'b1};
        vecs[2] = '{3'd5, 8'hFF,  8'h01,  8'h01,  1'b0};
        vecs[3] = '{3'd5, 8'h01,  8'hFF,  8'h00,  1'b0};
        vecs[4] = '{3'd2, 8'hF0,  8'h3C,  8'h30,  1'b0};
        vecs[5] = '{3'd4, 8'hAA,  8'hFF,  8'h55,  1'b0};
        vecs[6] = '{3'd6, 8'h81,  8'h0B,  8'h08,  1'b0};
        vecs[7] = '{3'd0, 8'h80,  8'h80,  8'h00,  1'b1};
        foreach (vecs[i]) begin
            run_op(vecs[i].o, vecs[i].x, vecs[i].y, lat, bcnt);
            check($sformatf("lat_op%0d", i), lat, 1);
            check($sformatf("result_op%0d", i), result, vecs[i].r);
            check($sformatf("carry_op%0d", i), carry, vecs[i].c);
            check($sformatf("zero_op%0d", i), zero, vecs[i].r == 0);
            drain();
        end

`ifdef ALU_MUL_EN
        run_op(3'd7, 8'd15, 8'd17, lat, bcnt);
        check("mul15x17_lat", lat, 9);
        check("mul15x17_busy_cycles", bcnt, 8);
        check("mul15x17_result", result, 255);
        check("mul15x17_carry", carry, 0);
        drain();
        run_op(3'd7, 8'd16, 8'd16, lat, bcnt);
        check("mul16x16_result", result, 0);
        check("mul16x16_carry", carry, 1);
        check("mul16x16_zero", zero, 1);
        drain();
`else
        run_op(3'd7, 8'd3, 8'd3, lat, bcnt);
        check("op7_lat", lat, 1);
        check("op7_busy_cycles", bcnt, 0);
        check("op7_result", result, 0);
        check("op7_carry", carry, 0);
        check("op7_zero", zero, 1);
        drain();
`endif

        // Backpressure followed by a back-to-back accept.
        out_ready = 1'b0;
        in_valid = 1'b1; op = 3'd0; a = 8'd1; b = 8'd1;
        @(negedge clk);
        @(posedge clk);
        #1;
        in_valid = 1'b0; a = 8'h55; b = 8'hAA;
        repeat (5) begin
            @(negedge clk);
            check("bp_out_valid", out_valid, 1);
            check("bp_result", result, 2);
            check("bp_in_ready", in_ready, 0);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b1; op = 3'd3; a = 8'h0F; b = 8'hF0; out_ready = 1'b1;
        @(negedge clk);
        check("b2b_in_ready", in_ready, 1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        @(negedge clk);
        check("b2b_out_valid", out_valid, 1);
        check("b2b_result", result, 8'hFF);
        drain();

        // Throughput: one op per clock with out_ready held high.
        tp[0] = '{3'd0, 8'h7F, 8'h01, 8'h80, 1'b0};
        tp[1] = '{3'd1, 8'h10, 8'h01, 8'h0F, 1'b0};
        tp[2] = '{3'd4, 8'h3C, 8'h0F, 8'h33, 1'b0};
        tp[3] = '{3'd5, 8'h80, 8'h7F, 8'h01, 1'b0};
        tp[4] = '{3'd6, 8'h01, 8'h07, 8'h80, 1'b0};
        tp[5] = '{3'd3, 8'h00, 8'h00, 8'h00, 1'b0};
        foreach (tp[i]) begin
            in_valid = 1'b1; op = tp[i].o; a = tp[i].x; b = tp[i].y;
            @(negedge clk);
            check($sformatf("tp_in_ready%0d", i), in_ready, 1);
            if (i > 0) check($sformatf("tp_result%0d", i - 1), result, tp[i - 1].r);
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        @(negedge clk);
        check("tp_last_result", result, 0);
        check("tp_last_zero", zero, 1);
        drain();

        // Reset three cycles after accepting op 111.
        out_ready = 1'b0;
        in_valid = 1'b1; op = 3'd7; a = 8'd15; b = 8'd17;
        @(negedge clk);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
`ifdef ALU_MUL_EN
        check("pre_rst_busy", busy, 1);
`else
        check("pre_rst_out_valid", out_valid, 1);
`endif
        rst = 1'b1;
        exp_q.delete();
        #1;
        check("abort_out_valid", out_valid, 0);
        check("abort_result", result, 0);
        check("abort_carry", carry, 0);
        check("abort_zero", zero, 0);
        check("abort_busy", busy, 0);
        check("abort_in_ready", in_ready, 1);
        @(posedge clk);
        #1;
        rst = 1'b0;
        out_ready = 1'b1;
        run_op(3'd0, 8'd3, 8'd4, lat, bcnt);
        check("post_abort_lat", lat, 1);
        check("post_abort_result", result, 7);
        check("post_abort_carry", carry, 0);
        drain();
        @(negedge clk);
        check("final_idle", out_valid, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

endmodule
